fan_pwm_tach_ctrl: RTL and testbench

- Multi-channel fan controller on the board CPLD, clocked from the PLL 7.8125 MHz output (clk0, 128 ns).
- Each fan channel generates a glitch-free PWM with a programmable duty. Duty changes are soft-ramped toward the target.
- Each channel measures tach pulses over a fixed window and detects stalled fans.
- Any stall forces every fan to full speed (failsafe). Replaces the single fixed-duty PWM0 generator.

---
 rtl/fan_pkg.sv | 12 +
 rtl/fan_tach_chan.sv | 82 ++++++++
 rtl/fan_pwm_tach_ctrl.sv | 117 +++++++++++
 tb/tb_fan_pwm_tach_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fan_pkg.sv
// Shared constants and helpers for the fan PWM / tach controller.
package fan_pkg;
  localparam int PWM_PERIOD_DEFAULT = 222;
  localparam int DUTY_DEFAULT       = 150;
  localparam int TACH_WINDOW_1S     = 7812500;
  localparam int CNT_W              = 16;

  // Counter width for n distinct states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/fan_tach_chan.sv
// One tach channel: synchroniser, majority glitch filter, saturating edge
// counter per window, and the sticky stall flag.
module fan_tach_chan
  import fan_pkg::*;
#(
  parameter int TACH_MIN     = 10,
  parameter int FAIL_WINDOWS = 3
) (
  input  logic             clk0,
  input  logic             rstn,
  input  logic             tach_raw,
  input  logic             win_end,
  input  logic             suppress,
  input  logic             fail_clr,
  output logic [CNT_W-1:0] tach_count,
  output logic             fan_fail
);
  localparam int MISS_W = clog2_min1(FAIL_WINDOWS + 1);

  logic              sync_p0, sync_p1;
  logic [1:0]        hist_p2;
  logic              filt_p3, filt_prev;
  logic              edge_det;
  logic [CNT_W-1:0]  edge_cnt, cnt_nxt;
  logic [MISS_W-1:0] miss_cnt, miss_nxt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  assign edge_det = filt_p3 & ~filt_prev;
  // The closing count includes an edge on the last window cycle.
  assign cnt_nxt  = sat_inc(edge_cnt, edge_det);
  assign miss_nxt = (miss_cnt < MISS_W'(FAIL_WINDOWS)) ? miss_cnt + MISS_W'(1) : miss_cnt;

  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      hist_p2    <= '0;
      filt_p3    <= 1'b0;
      filt_prev  <= 1'b0;
      edge_cnt   <= '0;
      tach_count <= '0;
      miss_cnt   <= '0;
      fan_fail   <= 1'b0;
    end else begin
      // p0/p1: metastability guard; p2: sample history; p3: filtered level
      sync_p0   <= tach_raw;
      sync_p1   <= sync_p0;
      hist_p2   <= {hist_p2[0], sync_p1};
      filt_p3   <= maj3(sync_p1, hist_p2[0], hist_p2[1]);
      filt_prev <= filt_p3;

      if (win_end) begin
        tach_count <= cnt_nxt;
        edge_cnt   <= '0;
      end else begin
        edge_cnt   <= cnt_nxt;
      end

      // A clear on the window-end cycle discards that window's verdict.
      if (fail_clr) begin
        miss_cnt <= '0;
        fan_fail <= 1'b0;
      end else if (suppress) begin
        miss_cnt <= '0;
      end else if (win_end) begin
        if (cnt_nxt < CNT_W'(TACH_MIN)) begin
          miss_cnt <= miss_nxt;
          if (miss_nxt >= MISS_W'(FAIL_WINDOWS)) fan_fail <= 1'b1;
        end else begin
          miss_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: rtl/fan_pwm_tach_ctrl.sv
// Multi-channel fan controller: shared PWM period, soft duty ramp, per-fan
// tach measurement and stall failsafe that drives every fan to full speed.
module fan_pwm_tach_ctrl
  import fan_pkg::*;
#(
  parameter int NUM_FANS     = 3,
  parameter int PWM_PERIOD   = PWM_PERIOD_DEFAULT,
  parameter int DUTY_DEFAULT = fan_pkg::DUTY_DEFAULT,
  parameter int RAMP_PERIODS = 4,
  parameter int TACH_WINDOW  = TACH_WINDOW_1S,
  parameter int TACH_MIN     = 10,
  parameter int FAIL_WINDOWS = 3
) (
  input  logic                         clk0,
  input  logic                         rstn,
  input  logic                         fan_en,
  input  logic                         duty_wr_en,
  input  logic [clog2_min1(NUM_FANS)-1:0] duty_wr_ch,
  input  logic [7:0]                   duty_wr_data,
  input  logic                         fail_clr,
  input  logic [NUM_FANS-1:0]          fan_tach,
  output logic [NUM_FANS-1:0]          fan_pwm,
  output logic [NUM_FANS*CNT_W-1:0]    tach_count,
  output logic                         tach_valid,
  output logic [NUM_FANS-1:0]          fan_fail,
  output logic                         failsafe
);
  localparam int         CH_W     = clog2_min1(NUM_FANS);
  localparam int         WIN_W    = clog2_min1(TACH_WINDOW);
  localparam int         RMP_W    = clog2_min1(RAMP_PERIODS);
  localparam logic [7:0] PERIOD_B = 8'(PWM_PERIOD);
  localparam logic [7:0] DUTY_RST = 8'(DUTY_DEFAULT);

  logic [7:0]                pwm_cnt;
  logic [RMP_W-1:0]          ramp_cnt;
  logic [WIN_W-1:0]          win_cnt;
  logic                      pwm_wrap, ramp_tick, win_end;
  logic [NUM_FANS-1:0][7:0]  tgt_duty, cur_duty;
  logic [NUM_FANS-1:0]       pwm_nxt, suppress;

  function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction

  function automatic logic [7:0] clamp_duty(input logic [7:0] d);
    return (d > PERIOD_B) ? PERIOD_B : d;
  endfunction

  assign pwm_wrap  = (pwm_cnt == PERIOD_B - 8'd1);
  assign ramp_tick = pwm_wrap && (ramp_cnt == RMP_W'(RAMP_PERIODS - 1));
  assign win_end   = (win_cnt == WIN_W'(TACH_WINDOW - 1));

  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
      win_cnt  <= '0;
    end else begin
      pwm_cnt <= pwm_wrap ? 8'd0 : pwm_cnt + 8'd1;
      if (pwm_wrap) ramp_cnt <= ramp_tick ? '0 : ramp_cnt + RMP_W'(1);
      win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
    end
  end

  // cur_duty only moves on the wrap edge, so every period keeps its length;
  // a write landing on a tick is seen by the following tick.
  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      tgt_duty <= {NUM_FANS{DUTY_RST}};
      cur_duty <= {NUM_FANS{DUTY_RST}};
    end else begin
      for (int i = 0; i < NUM_FANS; i++) begin
        if (ramp_tick) cur_duty[i] <= step_toward(cur_duty[i], tgt_duty[i]);
        if (duty_wr_en && (duty_wr_ch == CH_W'(i))) tgt_duty[i] <= duty_wr_data;
      end
    end
  end

  always_comb begin
    pwm_nxt  = '0;
    suppress = '0;
    for (int i = 0; i < NUM_FANS; i++) begin
      pwm_nxt[i]  = pwm_cnt < (failsafe ? PERIOD_B : clamp_duty(cur_duty[i]));
      suppress[i] = !fan_en || (tgt_duty[i] == 8'd0);
    end
  end

  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      fan_pwm    <= '0;
      failsafe   <= 1'b0;
      tach_valid <= 1'b0;
    end else begin
      fan_pwm    <= fan_en ? pwm_nxt : '0;
      failsafe   <= |fan_fail;
      tach_valid <= win_end;
    end
  end

  for (genvar g = 0; g < NUM_FANS; g++) begin : g_chan
    fan_tach_chan #(
      .TACH_MIN     (TACH_MIN),
      .FAIL_WINDOWS (FAIL_WINDOWS)
    ) u_chan (
      .clk0       (clk0),
      .rstn       (rstn),
      .tach_raw   (fan_tach[g]),
      .win_end    (win_end),
      .suppress   (suppress[g]),
      .fail_clr   (fail_clr),
      .tach_count (tach_count[CNT_W*g +: CNT_W]),
      .fan_fail   (fan_fail[g])
    );
  end
endmodule

// File: tb/tb_fan_pwm_tach_ctrl.sv
// Directed bench for fan_pwm_tach_ctrl with a 10-cycle PWM period and
// a 1000-cycle tach window.
module tb_fan_pwm_tach_ctrl;
  localparam int NF = 3;

  logic            clk0 = 1'b0;
  logic            rstn = 1'b0;
  logic            fan_en = 1'b0;
  logic            duty_wr_en = 1'b0;
  logic [1:0]      duty_wr_ch = '0;
  logic [7:0]      duty_wr_data = '0;
  logic            fail_clr = 1'b0;
  logic [NF-1:0]   fan_tach = '0;
  logic [NF-1:0]   fan_pwm;
  logic [NF*16-1:0] tach_count;
  logic            tach_valid;
  logic [NF-1:0]   fan_fail;
  logic            failsafe;

  int n_cmp = 0;
  int n_bad = 0;

  always #64 clk0 = ~clk0;

  fan_pwm_tach_ctrl #(
    .NUM_FANS     (NF),
    .PWM_PERIOD   (10),
    .DUTY_DEFAULT (6),
    .RAMP_PERIODS (1),
    .TACH_WINDOW  (1000),
    .TACH_MIN     (3),
    .FAIL_WINDOWS (2)
  ) dut (
    .clk0         (clk0),
    .rstn         (rstn),
    .fan_en       (fan_en),
    .duty_wr_en   (duty_wr_en),
    .duty_wr_ch   (duty_wr_ch),
    .duty_wr_data (duty_wr_data),
    .fail_clr     (fail_clr),
    .fan_tach     (fan_tach),
    .fan_pwm      (fan_pwm),
    .tach_count   (tach_count),
    .tach_valid   (tach_valid),
    .fan_fail     (fan_fail),
    .failsafe     (failsafe)
  );

  // Tach stimulus: tach_n[c] pulses of 10 cycles per 1000-cycle window,
  // plus optional single-cycle glitches at phases 60 and 600.
  int tach_n [NF] = '{5, 8, 8};
  bit glitch_en [NF] = '{1'b1, 1'b0, 1'b0};
  int tcyc = 0;

  always @(negedge clk0) begin
    int ph;
    logic [NF-1:0] t;
    if (!rstn) tcyc = 0;
    else tcyc++;
    ph = tcyc % 1000;
    t = '0;
    for (int c = 0; c < NF; c++) begin
      if (ph >= 100 && ph < 100 + 40 * tach_n[c] && ((ph - 100) % 40) < 10) t[c] = 1'b1;
      if (glitch_en[c] && (ph == 60 || ph == 600)) t[c] = 1'b1;
    end
    fan_tach = t;
  end

  // High-time and rise-to-rise period recorder for one channel.
  int rec_ch = 1;
  int hiq[$];
  int perq[$];
  int hi_run = 0;
  int since_rise = 0;
  bit seen_rise = 1'b0;
  logic prev_rec = 1'b0;

  always @(negedge clk0) begin
    logic cur;
    cur = fan_pwm[rec_ch];
    if (cur && !prev_rec) begin
      if (seen_rise) perq.push_back(since_rise);
      seen_rise = 1'b1;
      since_rise = 0;
    end
    since_rise++;
    if (cur) hi_run++;
    else if (prev_rec) begin
      hiq.push_back(hi_run);
      hi_run = 0;
    end
    prev_rec = cur;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic write_duty(input logic [1:0] ch, input logic [7:0] d);
    duty_wr_en   = 1'b1;
    duty_wr_ch   = ch;
    duty_wr_data = d;
    @(negedge clk0);
    duty_wr_en   = 1'b0;
  endtask

  task automatic count_hi(input int ch, input int n, output int hi);
    hi = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk0);
      if (fan_pwm[ch]) hi++;
    end
  endtask

  task automatic wait_rise(input int ch, input string tag);
    logic prev;
    bit got;
    got = 1'b0;
    @(negedge clk0);
    prev = fan_pwm[ch];
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk0);
      if (fan_pwm[ch] && !prev) got = 1'b1;
      prev = fan_pwm[ch];
    end
    check(tag, 64'(got), 64'd1);
  endtask

  task automatic wait_valid(input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 1100 && !got; k++) begin
      @(negedge clk0);
      if (tach_valid) got = 1'b1;
    end
    check(tag, 64'(got), 64'd1);
  endtask

  function automatic int tc(input int ch);
    return int'(tach_count[16*ch +: 16]);
  endfunction

  typedef struct {
    logic [1:0] ch;
    logic [7:0] duty;
    int         chk;
    int         exp_hi;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    repeat (60000) @(posedge clk0);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin : main
    int hi;
    int base;
    int exp_dn[6] = '{6, 5, 4, 3, 2, 2};
    int exp_up[4] = '{3, 4, 5, 5};
    int allhi;

    // {write ch, write duty, channel checked, expected high cycles per 10}
    vecs[0] = '{2'd3, 8'd0,   0, 6};
    vecs[1] = '{2'd3, 8'd0,   2, 6};
    vecs[2] = '{2'd0, 8'd8,   0, 8};
    vecs[3] = '{2'd2, 8'd3,   2, 3};
    vecs[4] = '{2'd0, 8'd6,   0, 6};
    vecs[5] = '{2'd2, 8'd6,   2, 6};
    vecs[6] = '{2'd1, 8'd0,   1, 0};
    vecs[7] = '{2'd1, 8'd255, 1, 10};

    repeat (3) @(negedge clk0);
    check("rst_fan_pwm", 64'(fan_pwm), 64'd0);
    check("rst_tach_count", 64'(tach_count), 64'd0);
    check("rst_tach_valid", 64'(tach_valid), 64'd0);
    check("rst_fan_fail", 64'(fan_fail), 64'd0);
    check("rst_failsafe", 64'(failsafe), 64'd0);

    rstn = 1'b1;
    fan_en = 1'b1;
    repeat (5) @(negedge clk0);
    for (int c = 0; c < NF; c++) begin
      count_hi(c, 40, hi);
      check($sformatf("default_duty_ch%0d", c), 64'(hi), 64'd24);
    end
    check("no_fail_after_reset", 64'(fan_fail), 64'd0);

    // ch1 ramp 6 -> 2, one step per period
    rec_ch = 1;
    wait_rise(1, "ramp_dn_rise");
    base = hiq.size();
    write_duty(2'd1, 8'd2);
    repeat (72) @(negedge clk0);
    for (int k = 0; k < 6; k++)
      check($sformatf("ramp_dn_hi[%0d]", k),
            64'((base + k < hiq.size()) ? hiq[base + k] : 0), 64'(exp_dn[k]));
    check("ramp_dn_periods_recorded", 64'(perq.size() >= 5), 64'd1);
    for (int k = 0; k < 5 && k < perq.size(); k++)
      check($sformatf("ramp_dn_period[%0d]", k), 64'(perq[perq.size() - 1 - k]), 64'd10);
    count_hi(0, 40, hi);
    check("ch0_steady_during_ramp", 64'(hi), 64'd24);

    for (int v = 0; v < 8; v++) begin
      write_duty(vecs[v].ch, vecs[v].duty);
      repeat (150) @(negedge clk0);
      count_hi(vecs[v].chk, 40, hi);
      check($sformatf("vec%0d_ch%0d_hi", v, vecs[v].chk), 64'(hi), 64'(vecs[v].exp_hi * 4));
    end

    // ch2 stalls (1 edge/window, glitches injected)
    wait_valid("sync_valid");
    tach_n[2] = 1;
    glitch_en[2] = 1'b1;
    wait_valid("winA_valid");
    check("winA_tach_ch0", 64'(tc(0)), 64'd5);
    check("winA_tach_ch1", 64'(tc(1)), 64'd8);
    check("winA_tach_ch2", 64'(tc(2)), 64'd1);
    check("winA_fan_fail", 64'(fan_fail), 64'd0);
    wait_valid("winB_valid");
    check("winB_fan_fail", 64'(fan_fail), 64'b100);
    check("winB_failsafe_lag", 64'(failsafe), 64'd0);
    @(negedge clk0);
    check("winB_failsafe", 64'(failsafe), 64'd1);
    write_duty(2'd0, 8'd3);
    repeat (2) @(negedge clk0);
    allhi = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk0);
      if (fan_pwm == 3'b111) allhi++;
    end
    check("failsafe_all_high", 64'(allhi), 64'd30);
    tach_n[2] = 8;
    glitch_en[2] = 1'b0;

    fail_clr = 1'b1;
    @(negedge clk0);
    fail_clr = 1'b0;
    check("clr_fan_fail", 64'(fan_fail), 64'd0);
    repeat (2) @(negedge clk0);
    check("clr_failsafe", 64'(failsafe), 64'd0);

    // ch0 ramp 3 -> 5 after the failsafe is cleared
    rec_ch = 0;
    repeat (3) @(negedge clk0);
    wait_rise(0, "ramp_up_rise");
    base = hiq.size();
    write_duty(2'd0, 8'd5);
    repeat (42) @(negedge clk0);
    for (int k = 0; k < 4; k++)
      check($sformatf("ramp_up_hi[%0d]", k),
            64'((base + k < hiq.size()) ? hiq[base + k] : 0), 64'(exp_up[k]));

    // fan_en=0 with dead tach: no stall may be flagged
    tach_n = '{0, 0, 0};
    glitch_en = '{1'b0, 1'b0, 1'b0};
    fan_en = 1'b0;
    @(negedge clk0);
    check("fan_en0_pwm", 64'(fan_pwm), 64'd0);
    for (int w = 0; w < 3; w++) begin
      wait_valid($sformatf("dis_win%0d_valid", w));
      check($sformatf("dis_win%0d_fan_fail", w), 64'(fan_fail), 64'd0);
    end
    check("dis_tach_count", 64'(tach_count), 64'd0);
    check("dis_failsafe", 64'(failsafe), 64'd0);

    // asynchronous reset mid-window
    fan_en = 1'b1;
    tach_n = '{5, 8, 8};
    wait_valid("pre_rst_valid0");
    wait_valid("pre_rst_valid1");
    check("pre_rst_tach_ch1", 64'(tc(1)), 64'd8);
    repeat (200) @(negedge clk0);
    check("pre_rst_pwm_ch1", 64'(fan_pwm[1]), 64'd1);
    #10 rstn = 1'b0;
    #1;
    check("arst_fan_pwm", 64'(fan_pwm), 64'd0);
    check("arst_tach_count", 64'(tach_count), 64'd0);
    check("arst_tach_valid", 64'(tach_valid), 64'd0);
    check("arst_fan_fail", 64'(fan_fail), 64'd0);
    check("arst_failsafe", 64'(failsafe), 64'd0);
    @(negedge clk0);
    rstn = 1'b1;
    repeat (3) @(negedge clk0);
    count_hi(1, 40, hi);
    check("post_rst_ch1_default", 64'(hi), 64'd24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
